// File: rtl/dct_coef_mac.sv
// Single-coefficient 8x8 DCT engine: buffers one 64-pixel block, then
// multiply-accumulates the level-shifted pixels against an external cosine LUT.
module dct_coef_mac (
    input  logic               clk,
    input  logic               rst,
    input  logic               pix_valid,
    input  logic [7:0]         pix_data,
    output logic               pix_ready,
    output logic [2:0]         n1,
    output logic [2:0]         n2,
    input  logic signed [31:0] cos_term,
    output logic               coef_valid,
    output logic signed [31:0] coef,
    input  logic               coef_ready
);

    localparam logic [1:0] ST_LOAD  = 2'd0;
    localparam logic [1:0] ST_MAC   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_OUT   = 2'd3;

    logic [1:0]         state_q, state_d;
    logic [5:0]         idx_q, idx_d;
    logic signed [47:0] acc_q, acc_d;
    logic signed [40:0] prod_q, prod_d;
    logic               coef_valid_q, coef_valid_d;
    logic signed [31:0] coef_q, coef_d;

    // The LUT answers n1/n2 in the same cycle, so the pixel must be read
    // combinationally from idx as well; 64x8 maps to distributed RAM.
    logic [7:0]         pix_mem [0:63];
    logic [7:0]         pix_rd;
    logic signed [8:0]  pix_centered;
    logic signed [40:0] prod_calc;
    logic signed [47:0] prod_ext;
    logic signed [31:0] acc_scaled;
    logic               pix_write;

    assign pix_write = (state_q == ST_LOAD) && pix_valid;

    always_ff @(posedge clk) begin
        if (pix_write) begin
            pix_mem[idx_q] <= pix_data;
        end
    end

    assign pix_rd       = pix_mem[idx_q];
    assign pix_centered = $signed({1'b0, pix_rd}) - 9'sd128;
    assign prod_calc    = 41'(pix_centered) * 41'(cos_term);
    assign prod_ext     = 48'(prod_q);
    // Bits [39:8] of the accumulator equal (acc >>> 8) truncated to 32 bits,
    // i.e. floor division by 256 for negative sums too.
    assign acc_scaled   = acc_q[39:8];

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        acc_d        = acc_q;
        prod_d       = prod_q;
        coef_valid_d = coef_valid_q;
        coef_d       = coef_q;
        case (state_q)
            ST_LOAD: begin
                if (pix_valid) begin
                    idx_d = idx_q + 6'd1;
                    if (idx_q == 6'd63) begin
                        acc_d   = '0;
                        state_d = ST_MAC;
                    end
                end
            end
            ST_MAC: begin
                prod_d = prod_calc;
                // prod_q holds a real product on every MAC cycle except the first.
                if (idx_q != 6'd0) begin
                    acc_d = acc_q + prod_ext;
                end
                idx_d = idx_q + 6'd1;
                if (idx_q == 6'd63) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                acc_d   = acc_q + prod_ext;
                state_d = ST_OUT;
            end
            default: begin
                if (!coef_valid_q) begin
                    coef_valid_d = 1'b1;
                    coef_d       = acc_scaled;
                end else if (coef_ready) begin
                    coef_valid_d = 1'b0;
                    state_d      = ST_LOAD;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_LOAD;
            idx_q        <= '0;
            acc_q        <= '0;
            prod_q       <= '0;
            coef_valid_q <= 1'b0;
            coef_q       <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            acc_q        <= acc_d;
            prod_q       <= prod_d;
            coef_valid_q <= coef_valid_d;
            coef_q       <= coef_d;
        end
    end

    assign pix_ready  = (state_q == ST_LOAD);
    assign n1         = (state_q == ST_MAC) ? idx_q[5:3] : 3'd0;
    assign n2         = (state_q == ST_MAC) ? idx_q[2:0] : 3'd0;
    assign coef_valid = coef_valid_q;
    assign coef       = coef_q;

endmodule

// File: tb/tb_dct_coef_mac.sv
// Directed bench for dct_coef_mac using the k1=0, k2=1 cosine LUT; every
// expected coefficient below was worked out by hand.
module tb_dct_coef_mac;

    logic               clk = 1'b0;
    logic               rst;
    logic               pix_valid;
    logic [7:0]         pix_data;
    logic               pix_ready;
    logic [2:0]         n1;
    logic [2:0]         n2;
    logic signed [31:0] cos_term;
    logic               coef_valid;
    logic signed [31:0] coef;
    logic               coef_ready;

    int tests = 0;
    int fails = 0;

    dct_coef_mac dut (
        .clk        (clk),
        .rst        (rst),
        .pix_valid  (pix_valid),
        .pix_data   (pix_data),
        .pix_ready  (pix_ready),
        .n1         (n1),
        .n2         (n2),
        .cos_term   (cos_term),
        .coef_valid (coef_valid),
        .coef       (coef),
        .coef_ready (coef_ready)
    );

    always #5 clk = ~clk;

    always_comb begin
        cos_term = 32'sd0;
        case (n2)
            3'd0: cos_term =  32'sd251;
            3'd1: cos_term =  32'sd212;
            3'd2: cos_term =  32'sd142;
            3'd3: cos_term =  32'sd49;
            3'd4: cos_term = -32'sd49;
            3'd5: cos_term = -32'sd142;
            3'd6: cos_term = -32'sd212;
            default: cos_term = -32'sd251;
        endcase
    end

    task automatic check(input string tag, input longint obs, input longint exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] pix_val(input int pattern, input int i);
        case (pattern)
            0: return 8'd128;
            1: return ((i % 8) < 4) ? 8'd255 : 8'd0;
            2: return (i == 0) ? 8'd255 : 8'd128;
            default: return (i == 0) ? 8'd0 : 8'd128;
        endcase
    endfunction

    // Feeds 64 pixels; returns once the 64th has been accepted at a posedge.
    task automatic load_block(input int pattern, input bit gaps);
        int i = 0;
        int guard = 0;
        bit rdy;
        while (i < 64 && guard < 1000) begin
            @(negedge clk);
            guard++;
            if (gaps && $urandom_range(0, 2) == 0) begin
                pix_valid = 1'b0;
            end else begin
                pix_valid = 1'b1;
                pix_data  = pix_val(pattern, i);
            end
            rdy = pix_ready;
            @(posedge clk);
            if (pix_valid && rdy) i++;
        end
        if (i < 64) check("load_timeout", i, 64);
    endtask

    // Waits for the coefficient, checking LUT sequencing, latency and value,
    // optionally stalls the output, then completes the handshake.
    task automatic finish_block(input string tag, input longint exp_coef, input bit hold);
        int  k = 0;
        int  nerr = 0;
        int  herr = 0;
        bit  seen = 1'b0;
        logic signed [31:0] held;
        while (!seen && k < 200) begin
            @(negedge clk);
            pix_valid = 1'b0;
            k++;
            if (k <= 64) begin
                if ({n1, n2} !== 6'(k - 1)) nerr++;
            end else if (n1 !== 3'd0 || n2 !== 3'd0) begin
                nerr++;
            end
            if (coef_valid === 1'b1) seen = 1'b1;
        end
        check({tag, "_lut_seq_errs"}, nerr, 0);
        check({tag, "_latency"}, k - 1, 66);
        check({tag, "_coef"}, coef, exp_coef);
        if (hold) begin
            held = coef;
            for (int c = 0; c < 10; c++) begin
                pix_valid = 1'b1;
                pix_data  = 8'd0;
                @(negedge clk);
                if (coef !== held || coef_valid !== 1'b1 || pix_ready !== 1'b0) herr++;
            end
            check({tag, "_hold_errs"}, herr, 0);
            pix_valid = 1'b0;
        end
        coef_ready = 1'b1;
        @(negedge clk);
        coef_ready = 1'b0;
        check({tag, "_valid_drop"}, coef_valid, 0);
        check({tag, "_back_to_load"}, pix_ready, 1);
    endtask

    initial begin
        int guard;
        rst        = 1'b1;
        pix_valid  = 1'b0;
        pix_data   = 8'd0;
        coef_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_pix_ready", pix_ready, 1);
        check("rst_coef_valid", coef_valid, 0);
        check("rst_coef", coef, 0);
        check("rst_n1", n1, 0);
        check("rst_n2", n2, 0);

        load_block(0, 1'b0);
        finish_block("flat128", 0, 1'b0);

        load_block(1, 1'b0);
        finish_block("half_step", 5211, 1'b1);
        check("half_step_acc", dut.acc_q, 1334160);

        load_block(2, 1'b0);
        finish_block("dc255", 124, 1'b0);

        load_block(3, 1'b0);
        finish_block("dc0_floor", -126, 1'b0);

        // Reset in the middle of MAC, with the LUT index at 30.
        load_block(1, 1'b0);
        guard = 0;
        do begin
            @(negedge clk);
            pix_valid = 1'b0;
            guard++;
        end while ({n1, n2} != 6'd30 && guard < 100);
        check("mid_mac_idx", {n1, n2}, 30);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_pix_ready", pix_ready, 1);
        check("midrst_coef_valid", coef_valid, 0);
        check("midrst_coef", coef, 0);
        check("midrst_n1n2", {n1, n2}, 0);
        load_block(0, 1'b0);
        finish_block("after_rst", 0, 1'b0);

        load_block(1, 1'b1);
        finish_block("gapped", 5211, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
